clk_sel_ctrl: RTL and testbench

Parametrised, glitch-safe clock-source selection controller for CH_NUM candidate clocks. It runs on one free-running reference clock and monitors a heartbeat toggle from each candidate clock domain to track liveness. It sequences every source change as gate-off, then select change, then settle, then gate-on. The block drives the select and enable of the downstream BUFGMUX/BUFGCE tree and can fail over automatically when the active source dies.

---
 rtl/clk_sel_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_clk_sel_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_sel_ctrl.sv
// Glitch-safe clock-source selection controller: heartbeat liveness tracking per
// candidate clock, gate-off / select / settle / gate-on sequencing, optional failover.
module clk_sel_ctrl #(
  parameter int CH_NUM      = 4,
  parameter int SEL_W       = $clog2(CH_NUM),
  parameter int SYNC_STAGES = 2,
  parameter int HB_TIMEOUT  = 64,
  parameter int GUARD_CYC   = 8,
  parameter int SETTLE_CYC  = 16,
  parameter int DEFAULT_SEL = 0
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [CH_NUM-1:0] hb_tgl_i,
  input  logic [SEL_W-1:0]  sel_req_i,
  input  logic              sel_req_vld_i,
  input  logic              auto_en_i,
  output logic [SEL_W-1:0]  mux_sel_o,
  output logic              clk_en_o,
  output logic [SEL_W-1:0]  sel_cur_o,
  output logic [CH_NUM-1:0] clk_alive_o,
  output logic              busy_o,
  output logic              req_err_o,
  output logic              failover_o,
  output logic              all_dead_o
);

  localparam int MAX_GS  = (GUARD_CYC > SETTLE_CYC) ? GUARD_CYC : SETTLE_CYC;
  localparam int MAX_CYC = (MAX_GS > HB_TIMEOUT) ? MAX_GS : HB_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] HB_MAX    = CNT_W'(HB_TIMEOUT);
  localparam logic [CNT_W-1:0] GUARD_M1  = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE_CYC - 1);
  localparam logic [SEL_W-1:0] DEF_SEL   = SEL_W'(DEFAULT_SEL);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_GATE_OFF, ST_SETTLE} state_t;

  logic [SYNC_STAGES-1:0] sync_q [CH_NUM];
  logic [SYNC_STAGES-1:0] sync_d [CH_NUM];
  logic [CNT_W-1:0]       hb_cnt_q [CH_NUM];
  logic [CNT_W-1:0]       hb_cnt_d [CH_NUM];
  logic [CH_NUM-1:0]      hb_prev_q, hb_prev_d;
  logic [CH_NUM-1:0]      alive_q, alive_d;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [SEL_W-1:0] tgt_q, tgt_d;
  logic [SEL_W-1:0] mux_sel_q, mux_sel_d;
  logic [SEL_W-1:0] sel_cur_q, sel_cur_d;
  logic             clk_en_q, clk_en_d;
  logic             busy_q, busy_d;
  logic             req_err_q, req_err_d;
  logic             failover_q, failover_d;
  logic             all_dead_q, all_dead_d;

  logic             fo_found;
  logic [SEL_W-1:0] fo_idx;
  logic             req_ok;
  logic             cur_dead;

  // A toggle seen at the synchroniser output restarts the silence counter.
  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      sync_d[i]    = {sync_q[i][SYNC_STAGES-2:0], hb_tgl_i[i]};
      hb_prev_d[i] = sync_q[i][SYNC_STAGES-1];
      if (sync_q[i][SYNC_STAGES-1] ^ hb_prev_q[i]) begin
        hb_cnt_d[i] = '0;
      end else if (hb_cnt_q[i] < HB_MAX) begin
        hb_cnt_d[i] = hb_cnt_q[i] + 1'b1;
      end else begin
        hb_cnt_d[i] = hb_cnt_q[i];
      end
      alive_d[i] = (hb_cnt_d[i] < HB_MAX);
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int i = 0; i < CH_NUM; i++) begin
        sync_q[i]   <= '0;
        hb_cnt_q[i] <= HB_MAX;
      end
      hb_prev_q <= '0;
      alive_q   <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        sync_q[i]   <= sync_d[i];
        hb_cnt_q[i] <= hb_cnt_d[i];
      end
      hb_prev_q <= hb_prev_d;
      alive_q   <= alive_d;
    end
  end

  // Lowest-index alive channel other than the active one.
  always_comb begin
    fo_found = 1'b0;
    fo_idx   = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      if (alive_q[i] && (SEL_W'(i) != sel_cur_q)) begin
        fo_found = 1'b1;
        fo_idx   = SEL_W'(i);
      end
    end
  end

  assign req_ok   = (int'(sel_req_i) < CH_NUM) && alive_q[sel_req_i];
  assign cur_dead = !alive_q[sel_cur_q];

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    tgt_d      = tgt_q;
    mux_sel_d  = mux_sel_q;
    sel_cur_d  = sel_cur_q;
    req_err_d  = 1'b0;
    failover_d = 1'b0;
    all_dead_d = 1'b0;
    case (state_q)
      ST_BOOT: begin
        req_err_d = sel_req_vld_i;
        if (alive_q[DEF_SEL]) begin
          state_d = ST_SETTLE;
          tmr_d   = SETTLE_M1;
          tgt_d   = DEF_SEL;
        end
      end
      ST_RUN: begin
        if (auto_en_i && cur_dead && fo_found) begin
          failover_d = 1'b1;
          req_err_d  = sel_req_vld_i;
          tgt_d      = fo_idx;
          state_d    = ST_GATE_OFF;
          tmr_d      = GUARD_M1;
        end else begin
          all_dead_d = auto_en_i && cur_dead;
          if (sel_req_vld_i) begin
            if (!req_ok) begin
              req_err_d = 1'b1;
            end else if (sel_req_i != sel_cur_q) begin
              tgt_d   = sel_req_i;
              state_d = ST_GATE_OFF;
              tmr_d   = GUARD_M1;
            end
          end
        end
      end
      ST_GATE_OFF: begin
        req_err_d = sel_req_vld_i;
        if (tmr_q == '0) begin
          state_d   = ST_SETTLE;
          tmr_d     = SETTLE_M1;
          mux_sel_d = tgt_q;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_SETTLE: begin
        req_err_d = sel_req_vld_i;
        if (tmr_q == '0) begin
          state_d   = ST_RUN;
          sel_cur_d = tgt_q;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    clk_en_d = (state_d == ST_RUN);
    busy_d   = (state_d != ST_RUN);
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= ST_BOOT;
      tmr_q      <= '0;
      tgt_q      <= DEF_SEL;
      mux_sel_q  <= DEF_SEL;
      sel_cur_q  <= DEF_SEL;
      clk_en_q   <= 1'b0;
      busy_q     <= 1'b1;
      req_err_q  <= 1'b0;
      failover_q <= 1'b0;
      all_dead_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      tgt_q      <= tgt_d;
      mux_sel_q  <= mux_sel_d;
      sel_cur_q  <= sel_cur_d;
      clk_en_q   <= clk_en_d;
      busy_q     <= busy_d;
      req_err_q  <= req_err_d;
      failover_q <= failover_d;
      all_dead_q <= all_dead_d;
    end
  end

  assign mux_sel_o   = mux_sel_q;
  assign clk_en_o    = clk_en_q;
  assign sel_cur_o   = sel_cur_q;
  assign clk_alive_o = alive_q;
  assign busy_o      = busy_q;
  assign req_err_o   = req_err_q;
  assign failover_o  = failover_q;
  assign all_dead_o  = all_dead_q;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Bench for clk_sel_ctrl: directed scenarios, a request table, and a randomized run
// compared every cycle against a time-stamp based behavioural model.
module tb_clk_sel_ctrl;
  localparam int CH  = 4;
  localparam int SW  = 2;
  localparam int SS  = 2;
  localparam int HBT = 64;
  localparam int GC  = 8;
  localparam int SC  = 16;
  localparam int DS  = 0;

  logic          clk_i    = 1'b0;
  logic          arst_n_i = 1'b0;
  logic [CH-1:0] hb       = '0;
  logic [SW-1:0] sel_req  = '0;
  logic          vld      = 1'b0;
  logic          auto_en  = 1'b0;

  logic [SW-1:0] mux_sel_o, sel_cur_o;
  logic [CH-1:0] clk_alive_o;
  logic          clk_en_o, busy_o, req_err_o, failover_o, all_dead_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mdl_on = 1'b0;

  clk_sel_ctrl #(
    .CH_NUM(CH), .SEL_W(SW), .SYNC_STAGES(SS), .HB_TIMEOUT(HBT),
    .GUARD_CYC(GC), .SETTLE_CYC(SC), .DEFAULT_SEL(DS)
  ) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .hb_tgl_i(hb), .sel_req_i(sel_req),
    .sel_req_vld_i(vld), .auto_en_i(auto_en), .mux_sel_o(mux_sel_o),
    .clk_en_o(clk_en_o), .sel_cur_o(sel_cur_o), .clk_alive_o(clk_alive_o),
    .busy_o(busy_o), .req_err_o(req_err_o), .failover_o(failover_o),
    .all_dead_o(all_dead_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Heartbeat generators: each running channel toggles every hb_iv cycles.
  bit [CH-1:0] hb_run = '0;
  int hb_iv[CH] = '{default: 4};
  int hb_cd[CH] = '{default: 0};
  always @(negedge clk_i) begin
    for (int i = 0; i < CH; i++) begin
      if (hb_run[i]) begin
        if (hb_cd[i] <= 0) begin
          hb[i] = ~hb[i];
          hb_cd[i] = hb_iv[i] - 1;
        end else begin
          hb_cd[i]--;
        end
      end
    end
  end

  // Reference model: liveness from the time of the last synchronised toggle,
  // switching phases from the time the switch was accepted.
  int            k;
  int            last_evt[CH];
  logic [CH-1:0] hq[$];
  logic [CH-1:0] m_alive, pa;
  bit            m_running, m_boot, m_req_err, m_fo, m_dead, started, found_ok;
  logic [SW-1:0] m_cur, m_tgt, m_mux, found;
  int            m_mux_at, m_run_at;

  always @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      k = 0;
      for (int i = 0; i < CH; i++) last_evt[i] = -1000;
      hq.delete();
      repeat (SS + 1) hq.push_back('0);
      m_alive = '0; m_running = 0; m_boot = 1;
      m_req_err = 0; m_fo = 0; m_dead = 0;
      m_cur = SW'(DS); m_tgt = SW'(DS); m_mux = SW'(DS);
      m_mux_at = -1; m_run_at = -1;
    end else begin
      k++;
      hq.push_back(hb);
      if (hq.size() > SS + 2) void'(hq.pop_front());
      pa = m_alive;
      for (int i = 0; i < CH; i++) begin
        if (hq[1][i] != hq[0][i]) last_evt[i] = k;
        m_alive[i] = (k - last_evt[i]) < HBT;
      end
      m_req_err = 0; m_fo = 0; m_dead = 0;
      if (!m_running) begin
        m_req_err = vld;
        if (m_boot) begin
          if (pa[DS]) begin
            m_boot = 0;
            m_run_at = k + SC;
          end
        end else begin
          if (k == m_mux_at) m_mux = m_tgt;
          if (k == m_run_at) begin
            m_running = 1;
            m_cur = m_tgt;
          end
        end
      end else begin
        started = 0;
        if (auto_en && !pa[m_cur]) begin
          found_ok = 0; found = '0;
          for (int i = CH - 1; i >= 0; i--)
            if (pa[i] && SW'(i) != m_cur) begin found_ok = 1; found = SW'(i); end
          if (found_ok) begin
            m_fo = 1; m_req_err = vld; started = 1;
            m_tgt = found;
          end else begin
            m_dead = 1;
          end
        end
        if (!started && vld) begin
          if (int'(sel_req) >= CH || !pa[sel_req]) m_req_err = 1;
          else if (sel_req != m_cur) begin
            started = 1;
            m_tgt = sel_req;
          end
        end
        if (started) begin
          m_running = 0;
          m_mux_at = k + GC;
          m_run_at = k + GC + SC;
        end
      end
    end
  end

  logic [SW-1:0] prev_mux = '0;
  logic          prev_en  = 1'b0;
  always @(negedge clk_i) begin
    if (mdl_on) begin
      chk("m_clk_en",   32'(clk_en_o),    32'(m_running));
      chk("m_busy",     32'(busy_o),      32'(!m_running));
      chk("m_mux_sel",  32'(mux_sel_o),   32'(m_mux));
      chk("m_sel_cur",  32'(sel_cur_o),   32'(m_cur));
      chk("m_alive",    32'(clk_alive_o), 32'(m_alive));
      chk("m_req_err",  32'(req_err_o),   32'(m_req_err));
      chk("m_failover", 32'(failover_o),  32'(m_fo));
      chk("m_all_dead", 32'(all_dead_o),  32'(m_dead));
      if (mux_sel_o != prev_mux) chk("mux_while_en", 32'(clk_en_o | prev_en), 32'd0);
    end
    prev_mux = mux_sel_o;
    prev_en  = clk_en_o;
  end

  typedef struct {
    logic [SW-1:0] sel;
    bit            err;
    bit            sw;
    logic [SW-1:0] cur_after;
  } vec_t;
  vec_t vt[6];

  int  ca, fall;
  bit  seen;
  logic prev_a2;

  initial begin
    vt[0] = '{sel: 2'd3, err: 1'b1, sw: 1'b0, cur_after: 2'd2};
    vt[1] = '{sel: 2'd1, err: 1'b1, sw: 1'b0, cur_after: 2'd2};
    vt[2] = '{sel: 2'd2, err: 1'b0, sw: 1'b0, cur_after: 2'd2};
    vt[3] = '{sel: 2'd0, err: 1'b0, sw: 1'b1, cur_after: 2'd0};
    vt[4] = '{sel: 2'd0, err: 1'b0, sw: 1'b0, cur_after: 2'd0};
    vt[5] = '{sel: 2'd2, err: 1'b0, sw: 1'b1, cur_after: 2'd2};

    repeat (2) @(posedge clk_i);
    mdl_on = 1'b1;
    #1;
    chk("rst_clk_en",   32'(clk_en_o),    32'd0);
    chk("rst_busy",     32'(busy_o),      32'd1);
    chk("rst_mux",      32'(mux_sel_o),   32'(DS));
    chk("rst_cur",      32'(sel_cur_o),   32'(DS));
    chk("rst_alive",    32'(clk_alive_o), 32'd0);
    chk("rst_pulses",   32'({req_err_o, failover_o, all_dead_o}), 32'd0);
    step();
    arst_n_i = 1'b1;

    // Boot on channel 0.
    hb_iv[0] = 4; hb_iv[2] = 3;
    hb_run[0] = 1'b1; hb_run[2] = 1'b1;
    seen = 0; ca = 0;
    for (int n = 0; n < 60 && !seen; n++) begin
      step();
      chk("boot_mux", 32'(mux_sel_o), 32'd0);
      if (clk_alive_o[0]) begin seen = 1; ca = cyc; end
    end
    chk("boot_alive_seen", 32'(seen), 32'd1);
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      step();
      chk("boot_mux", 32'(mux_sel_o), 32'd0);
      if (clk_en_o) seen = 1;
    end
    chk("boot_en_seen", 32'(seen), 32'd1);
    chk("boot_latency", 32'(cyc - ca), 32'd17);

    // Switch 0 -> 2 with a rejected request in the middle of the gate-off.
    step();
    sel_req = 2'd2; vld = 1'b1;
    for (int d = 1; d <= 26; d++) begin
      step();
      if (d == 1 || d == 4) vld = 1'b0;
      chk("sw_clk_en",  32'(clk_en_o),  32'(d >= 25));
      chk("sw_busy",    32'(busy_o),    32'(d < 25));
      chk("sw_mux",     32'(mux_sel_o), (d >= 9) ? 32'd2 : 32'd0);
      chk("sw_cur",     32'(sel_cur_o), (d >= 25) ? 32'd2 : 32'd0);
      chk("sw_req_err", 32'(req_err_o), 32'(d == 4));
      if (d == 3) begin sel_req = 2'd1; vld = 1'b1; end
    end

    // Request table from the running state.
    for (int t = 0; t < 6; t++) begin
      sel_req = vt[t].sel; vld = 1'b1;
      step();
      vld = 1'b0;
      chk("tbl_err",  32'(req_err_o), 32'(vt[t].err));
      chk("tbl_busy", 32'(busy_o),    32'(vt[t].sw));
      step();
      chk("tbl_err_clr", 32'(req_err_o), 32'd0);
      if (vt[t].sw) repeat (30) step();
      chk("tbl_cur", 32'(sel_cur_o), 32'(vt[t].cur_after));
      chk("tbl_en",  32'(clk_en_o),  32'd1);
    end

    // Failover from a dying ch2 to ch1.
    hb_run[0] = 1'b0; hb_run[1] = 1'b1;
    repeat (100) step();
    auto_en = 1'b1;
    hb_run[2] = 1'b0;
    seen = 0; fall = 0; prev_a2 = clk_alive_o[2];
    for (int n = 0; n < 150 && !seen; n++) begin
      step();
      if (prev_a2 && !clk_alive_o[2]) fall = cyc;
      prev_a2 = clk_alive_o[2];
      if (failover_o) seen = 1;
    end
    chk("fo_seen", 32'(seen), 32'd1);
    chk("fo_after_fall", 32'(cyc - fall), 32'd1);
    repeat (30) step();
    chk("fo_cur", 32'(sel_cur_o), 32'd1);
    chk("fo_mux", 32'(mux_sel_o), 32'd1);
    chk("fo_en",  32'(clk_en_o),  32'd1);

    // Every source dead, then ch3 comes up.
    hb_run[1] = 1'b0;
    seen = 0;
    for (int n = 0; n < 150 && !seen; n++) begin
      step();
      if (all_dead_o) seen = 1;
    end
    chk("dead_seen", 32'(seen), 32'd1);
    repeat (10) step();
    chk("dead_hold", 32'(all_dead_o), 32'd1);
    chk("dead_en",   32'(clk_en_o),   32'd1);
    chk("dead_mux",  32'(mux_sel_o),  32'd1);
    hb_iv[3] = 4; hb_run[3] = 1'b1;
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      step();
      if (failover_o) seen = 1;
    end
    chk("revive_fo", 32'(seen), 32'd1);
    chk("revive_dead_clr", 32'(all_dead_o), 32'd0);
    repeat (30) step();
    chk("revive_cur", 32'(sel_cur_o), 32'd3);

    // Asynchronous reset in the middle of a gate-off.
    hb_run[0] = 1'b1;
    repeat (20) step();
    auto_en = 1'b0;
    sel_req = 2'd0; vld = 1'b1;
    step();
    vld = 1'b0;
    repeat (3) step();
    chk("pre_rst_mux", 32'(mux_sel_o), 32'd3);
    #2;
    arst_n_i = 1'b0;
    #1;
    chk("arst_clk_en", 32'(clk_en_o),    32'd0);
    chk("arst_mux",    32'(mux_sel_o),   32'(DS));
    chk("arst_busy",   32'(busy_o),      32'd1);
    chk("arst_alive",  32'(clk_alive_o), 32'd0);
    chk("arst_cur",    32'(sel_cur_o),   32'(DS));
    repeat (3) step();
    arst_n_i = 1'b1;

    // Randomized traffic against the model.
    hb_run = 4'b1111;
    for (int n = 0; n < 6000; n++) begin
      step();
      vld = ($urandom_range(0, 7) == 0);
      sel_req = SW'($urandom_range(0, CH - 1));
      if ($urandom_range(0, 119) == 0) begin
        int c;
        c = $urandom_range(0, CH - 1);
        hb_run[c] = ~hb_run[c];
        hb_iv[c] = $urandom_range(2, 6);
      end
      if ($urandom_range(0, 299) == 0) auto_en = ~auto_en;
    end
    vld = 1'b0;
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
